// File: rtl/edic_ctrl_pkg.sv
// Shared types for the EDIC control sequencer: opcodes, FSM states,
// jump conditions, instruction-field bit positions and the control bundle.
package edic_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_NOP = 3'b000,
    OP_LDI = 3'b001,
    OP_ALU = 3'b010,
    OP_ST  = 3'b011,
    OP_LD  = 3'b100,
    OP_JMP = 3'b101,
    OP_JCC = 3'b110,
    OP_HLT = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    S_FETCH0 = 3'd0,
    S_FETCH1 = 3'd1,
    S_EXEC0  = 3'd2,
    S_EXEC1  = 3'd3,
    S_EXEC2  = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    COND_Z  = 2'b00,
    COND_NZ = 2'b01,
    COND_N  = 2'b10,
    COND_NN = 2'b11
  } cond_e;

  // Instruction register field positions
  localparam int unsigned IR_OP_MSB = 7;
  localparam int unsigned IR_OP_LSB = 5;
  localparam int unsigned IR_RD     = 4;
  localparam int unsigned IR_RS     = 3;
  localparam int unsigned IR_SUB    = 2;
  localparam int unsigned IR_FN_MSB = 1;
  localparam int unsigned IR_FN_LSB = 0;

  // ALU function code that selects the shifter; IR[2] then means shift-left
  localparam logic [1:0] ALU_FN_SHIFT = 2'b11;

  typedef struct packed {
    logic       aluOE;
    logic       aluSub;
    logic [1:0] aluOp;
    logic       aluBWr;
    logic       aluShiftLeft;
    logic       aluSel;
    logic       regWr0;
    logic       regWr1;
    logic       regBusSel;
    logic       regBusEn;
    logic       ramAddressEn;
    logic       ramWriteEn;
    logic       ramReadDataSelect;
    logic       ramOE;
    logic       loadPC;
    logic       incrPC;
    logic       pcOe;
  } ctrl_t;

  function automatic opcode_e irOpcode(input logic [7:0] ir);
    return opcode_e'(ir[IR_OP_MSB:IR_OP_LSB]);
  endfunction

  function automatic logic condMet(input cond_e c, input logic n, input logic z);
    case (c)
      COND_Z:  return z;
      COND_NZ: return !z;
      COND_N:  return n;
      default: return !n;
    endcase
  endfunction

endpackage

// File: rtl/control_decode.sv
// Moore decode of sequencer state + instruction register into datapath
// control strobes. Purely combinational.
import edic_ctrl_pkg::*;

module control_decode (
  input  state_e     i_state,
  input  logic [7:0] i_ir,
  input  logic       i_flagN,
  input  logic       i_flagZ,
  output ctrl_t      o_ctrl,
  output logic       o_halted
);

  opcode_e    op;
  logic       rd;
  logic       rs;
  logic       sub;
  logic [1:0] fn;
  logic       jccTaken;

  assign op       = irOpcode(i_ir);
  assign rd       = i_ir[IR_RD];
  assign rs       = i_ir[IR_RS];
  assign sub      = i_ir[IR_SUB];
  assign fn       = i_ir[IR_FN_MSB:IR_FN_LSB];
  assign jccTaken = condMet(cond_e'(fn), i_flagN, i_flagZ);

  // Per-state, per-opcode control strobes; everything idles low by default
  always_comb begin
    o_ctrl   = '0;
    o_halted = 1'b0;
    case (i_state)
      S_FETCH0: begin
        o_ctrl.pcOe         = 1'b1;
        o_ctrl.ramAddressEn = 1'b1;
      end
      S_FETCH1: begin
        o_ctrl.ramReadDataSelect = 1'b1;
        o_ctrl.ramOE             = 1'b1;
        o_ctrl.incrPC            = 1'b1;
      end
      S_EXEC0: begin
        case (op)
          OP_LDI, OP_JMP, OP_JCC: begin
            o_ctrl.pcOe         = 1'b1;
            o_ctrl.ramAddressEn = 1'b1;
          end
          OP_ALU: begin
            o_ctrl.regBusSel = rs;
            o_ctrl.regBusEn  = 1'b1;
            o_ctrl.aluBWr    = 1'b1;
          end
          OP_ST, OP_LD: begin
            o_ctrl.regBusSel    = rs;
            o_ctrl.regBusEn     = 1'b1;
            o_ctrl.ramAddressEn = 1'b1;
          end
          default: ;
        endcase
      end
      S_EXEC1: begin
        case (op)
          OP_LDI: begin
            o_ctrl.ramReadDataSelect = 1'b1;
            o_ctrl.ramOE             = 1'b1;
            o_ctrl.regWr0            = !rd;
            o_ctrl.regWr1            = rd;
            o_ctrl.incrPC            = 1'b1;
          end
          OP_JMP: begin
            o_ctrl.ramReadDataSelect = 1'b1;
            o_ctrl.ramOE             = 1'b1;
            o_ctrl.loadPC            = 1'b1;
          end
          OP_JCC: begin
            o_ctrl.ramReadDataSelect = 1'b1;
            o_ctrl.ramOE             = 1'b1;
            o_ctrl.loadPC            = jccTaken;
            o_ctrl.incrPC            = !jccTaken;
          end
          OP_ALU: begin
            o_ctrl.aluSel       = rd;
            o_ctrl.aluOp        = fn;
            o_ctrl.aluSub       = sub & (fn != ALU_FN_SHIFT);
            o_ctrl.aluShiftLeft = sub & (fn == ALU_FN_SHIFT);
          end
          OP_ST: begin
            o_ctrl.regBusSel  = !rs;
            o_ctrl.regBusEn   = 1'b1;
            o_ctrl.ramWriteEn = 1'b1;
          end
          OP_LD: begin
            o_ctrl.ramReadDataSelect = 1'b1;
            o_ctrl.ramOE             = 1'b1;
            o_ctrl.regWr0            = !rd;
            o_ctrl.regWr1            = rd;
          end
          default: ;
        endcase
      end
      S_EXEC2: begin
        if (op == OP_ALU) begin
          o_ctrl.aluSel       = rd;
          o_ctrl.aluOp        = fn;
          o_ctrl.aluSub       = sub & (fn != ALU_FN_SHIFT);
          o_ctrl.aluShiftLeft = sub & (fn == ALU_FN_SHIFT);
          o_ctrl.aluOE        = 1'b1;
          o_ctrl.regWr0       = !rd;
          o_ctrl.regWr1       = rd;
        end
      end
      S_HALT: o_halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// EDIC control sequencer: fetch/execute FSM, instruction register and
// optional ALU flag latch. Define CTRL_SEQ_FLAG_LATCH_EN to make JCC test
// flags captured at the end of the last ALU instruction instead of the
// live ALU flag inputs.
import edic_ctrl_pkg::*;

module control_sequencer (
  input  logic       i_clk,
  input  logic       i_nReset,
  input  logic [7:0] i_bus,
  input  logic       i_aluFlagN,
  input  logic       i_aluFlagZ,
  output logic       o_halted,
  output logic       o_ctrlAluOE,
  output logic       o_ctrlAluSub,
  output logic [1:0] o_ctrlAluOp,
  output logic       o_ctrlAluBWr,
  output logic       o_ctrlAluShiftLeft,
  output logic       o_ctrlAluSel,
  output logic       o_ctrlRegWr0,
  output logic       o_ctrlRegWr1,
  output logic       o_ctrlRegBusSel,
  output logic       o_ctrlRegBusEn,
  output logic       o_ctrlRamAddressEn,
  output logic       o_ctrlRamWriteEn,
  output logic       o_ctrlRamReadDataSelect,
  output logic       o_ctrlRamOE,
  output logic       o_ctrlLoadPC,
  output logic       o_ctrlIncrPC,
  output logic       o_ctrlPCOe
);

  state_e     state;
  state_e     stateNext;
  logic [7:0] ir;
  logic       flagN;
  logic       flagZ;
  ctrl_t      ctrlDec;
  ctrl_t      ctrlOut;
  logic       haltedDec;

  // State register
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) state <= S_FETCH0;
    else           state <= stateNext;
  end

  // Instruction register loads the opcode byte at the end of FETCH1
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset)               ir <= '0;
    else if (state == S_FETCH1)  ir <= i_bus;
  end

  // Next-state; FETCH1 routes on the byte on the bus since IR loads at the same edge
  always_comb begin
    stateNext = state;
    case (state)
      S_FETCH0: stateNext = S_FETCH1;
      S_FETCH1: begin
        case (irOpcode(i_bus))
          OP_HLT:  stateNext = S_HALT;
          OP_NOP:  stateNext = S_FETCH0;
          default: stateNext = S_EXEC0;
        endcase
      end
      S_EXEC0: stateNext = S_EXEC1;
      S_EXEC1: stateNext = (irOpcode(ir) == OP_ALU) ? S_EXEC2 : S_FETCH0;
      S_EXEC2: stateNext = S_FETCH0;
      S_HALT:  stateNext = S_HALT;
      default: stateNext = S_FETCH0;
    endcase
  end

`ifdef CTRL_SEQ_FLAG_LATCH_EN
  logic [1:0] flagReg;

  // {N,Z} captured at the close of the ALU write-back cycle
  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset)
      flagReg <= '0;
    else if (state == S_EXEC2 && irOpcode(ir) == OP_ALU)
      flagReg <= {i_aluFlagN, i_aluFlagZ};
  end

  assign flagN = flagReg[1];
  assign flagZ = flagReg[0];
`else
  assign flagN = i_aluFlagN;
  assign flagZ = i_aluFlagZ;
`endif

  control_decode uDecode (
    .i_state  (state),
    .i_ir     (ir),
    .i_flagN  (flagN),
    .i_flagZ  (flagZ),
    .o_ctrl   (ctrlDec),
    .o_halted (haltedDec)
  );

  // Reset state is FETCH0, whose decode drives PCOe; gating with the reset
  // pin keeps every strobe low for as long as reset is held.
  assign ctrlOut  = i_nReset ? ctrlDec : '0;
  assign o_halted = i_nReset & haltedDec;

  assign o_ctrlAluOE             = ctrlOut.aluOE;
  assign o_ctrlAluSub            = ctrlOut.aluSub;
  assign o_ctrlAluOp             = ctrlOut.aluOp;
  assign o_ctrlAluBWr            = ctrlOut.aluBWr;
  assign o_ctrlAluShiftLeft      = ctrlOut.aluShiftLeft;
  assign o_ctrlAluSel            = ctrlOut.aluSel;
  assign o_ctrlRegWr0            = ctrlOut.regWr0;
  assign o_ctrlRegWr1            = ctrlOut.regWr1;
  assign o_ctrlRegBusSel         = ctrlOut.regBusSel;
  assign o_ctrlRegBusEn          = ctrlOut.regBusEn;
  assign o_ctrlRamAddressEn      = ctrlOut.ramAddressEn;
  assign o_ctrlRamWriteEn        = ctrlOut.ramWriteEn;
  assign o_ctrlRamReadDataSelect = ctrlOut.ramReadDataSelect;
  assign o_ctrlRamOE             = ctrlOut.ramOE;
  assign o_ctrlLoadPC            = ctrlOut.loadPC;
  assign o_ctrlIncrPC            = ctrlOut.incrPC;
  assign o_ctrlPCOe              = ctrlOut.pcOe;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer.
module tb_control_sequencer;

  logic       i_clk = 1'b0;
  logic       i_nReset;
  logic [7:0] i_bus;
  logic       i_aluFlagN;
  logic       i_aluFlagZ;
  logic       o_halted;
  logic       o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluBWr, o_ctrlAluShiftLeft, o_ctrlAluSel;
  logic [1:0] o_ctrlAluOp;
  logic       o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn;
  logic       o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect, o_ctrlRamOE;
  logic       o_ctrlLoadPC, o_ctrlIncrPC, o_ctrlPCOe;

  int checks = 0;
  int errors = 0;

`ifdef CTRL_SEQ_FLAG_LATCH_EN
  localparam bit LATCHED = 1'b1;
`else
  localparam bit LATCHED = 1'b0;
`endif

  // Observation vector bit positions
  localparam logic [18:0] PCOE      = 19'h00001;
  localparam logic [18:0] INCR      = 19'h00002;
  localparam logic [18:0] LOADPC    = 19'h00004;
  localparam logic [18:0] RAMOE     = 19'h00008;
  localparam logic [18:0] RDSEL     = 19'h00010;
  localparam logic [18:0] RAMWE     = 19'h00020;
  localparam logic [18:0] RAMADDR   = 19'h00040;
  localparam logic [18:0] REGBUSEN  = 19'h00080;
  localparam logic [18:0] REGBUSSEL = 19'h00100;
  localparam logic [18:0] REGWR1    = 19'h00200;
  localparam logic [18:0] REGWR0    = 19'h00400;
  localparam logic [18:0] ALUSEL    = 19'h00800;
  localparam logic [18:0] SHL       = 19'h01000;
  localparam logic [18:0] ALUBWR    = 19'h02000;
  localparam logic [18:0] OP1       = 19'h04000;
  localparam logic [18:0] OP3       = 19'h0C000;
  localparam logic [18:0] ALUSUB    = 19'h10000;
  localparam logic [18:0] ALUOE     = 19'h20000;
  localparam logic [18:0] HALTED    = 19'h40000;
  localparam logic [18:0] F0V       = PCOE | RAMADDR;
  localparam logic [18:0] F1V       = RDSEL | RAMOE | INCR;

  logic [18:0] obs;
  assign obs = {o_halted, o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluOp, o_ctrlAluBWr,
                o_ctrlAluShiftLeft, o_ctrlAluSel, o_ctrlRegWr0, o_ctrlRegWr1,
                o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlRamAddressEn, o_ctrlRamWriteEn,
                o_ctrlRamReadDataSelect, o_ctrlRamOE, o_ctrlLoadPC, o_ctrlIncrPC, o_ctrlPCOe};

  typedef struct packed {
    logic       aZ;
    logic       aN;
    logic [7:0] ir;
    logic       jZ;
    logic       jN;
    logic       tLatch;
    logic       tLive;
  } jcase_t;

  control_sequencer dut (
    .i_clk                   (i_clk),
    .i_nReset                (i_nReset),
    .i_bus                   (i_bus),
    .i_aluFlagN              (i_aluFlagN),
    .i_aluFlagZ              (i_aluFlagZ),
    .o_halted                (o_halted),
    .o_ctrlAluOE             (o_ctrlAluOE),
    .o_ctrlAluSub            (o_ctrlAluSub),
    .o_ctrlAluOp             (o_ctrlAluOp),
    .o_ctrlAluBWr            (o_ctrlAluBWr),
    .o_ctrlAluShiftLeft      (o_ctrlAluShiftLeft),
    .o_ctrlAluSel            (o_ctrlAluSel),
    .o_ctrlRegWr0            (o_ctrlRegWr0),
    .o_ctrlRegWr1            (o_ctrlRegWr1),
    .o_ctrlRegBusSel         (o_ctrlRegBusSel),
    .o_ctrlRegBusEn          (o_ctrlRegBusEn),
    .o_ctrlRamAddressEn      (o_ctrlRamAddressEn),
    .o_ctrlRamWriteEn        (o_ctrlRamWriteEn),
    .o_ctrlRamReadDataSelect (o_ctrlRamReadDataSelect),
    .o_ctrlRamOE             (o_ctrlRamOE),
    .o_ctrlLoadPC            (o_ctrlLoadPC),
    .o_ctrlIncrPC            (o_ctrlIncrPC),
    .o_ctrlPCOe              (o_ctrlPCOe)
  );

  always #5 i_clk = ~i_clk;

  // Bus-driver exclusivity and single register write, every active cycle
  always @(negedge i_clk) begin
    if (i_nReset === 1'b1) begin
      checks = checks + 1;
      if (!$onehot0({o_ctrlAluOE, o_ctrlRegBusEn, o_ctrlRamOE, o_ctrlPCOe}) ||
          (o_ctrlRegWr0 && o_ctrlRegWr1)) begin
        errors = errors + 1;
        $display("FAIL exclusive obs=%h", obs);
      end
    end
  end

  logic watchWe = 1'b0;
  logic weSeen  = 1'b0;
  always @(posedge o_ctrlRamWriteEn) if (watchWe) weSeen = 1'b1;

  // Enter FETCH0 with reset just released on a falling edge
  task automatic doReset();
    i_nReset = 1'b0;
    i_bus = 8'h00;
    repeat (2) @(negedge i_clk);
    i_nReset = 1'b1;
  endtask

  task automatic test_reset();
    i_nReset = 1'b0;
    for (int unsigned i = 0; i < 10; i++) begin
      @(negedge i_clk);
      i_bus = 8'($urandom);
      i_aluFlagN = 1'($urandom);
      i_aluFlagZ = 1'($urandom);
      #1;
      checks++;
      if (obs !== 19'h0) begin
        errors++;
        $display("FAIL reset_hold cycle=%0d got=%h want=%h", i, obs, 19'h0);
      end
    end
    i_aluFlagN = 1'b0;
    i_aluFlagZ = 1'b0;
    @(negedge i_clk);
    i_nReset = 1'b1;
    i_bus = 8'h00;
    #1;
    checks++;
    if (obs !== F0V) begin
      errors++;
      $display("FAIL reset_release got=%h want=%h", obs, F0V);
    end
    @(negedge i_clk); #1;
    checks++;
    if (obs !== F1V) begin
      errors++;
      $display("FAIL reset_fetch1 got=%h want=%h", obs, F1V);
    end
  endtask

  task automatic test_four_cycle();
    logic [7:0]  irs [7];
    logic [18:0] e0 [7];
    logic [18:0] e1 [7];
    int unsigned incs [7];
    logic [18:0] exp4 [4];
    logic [7:0]  bus4 [4];
    int unsigned incCount;
    irs  = '{8'h20, 8'h30, 8'hA0, 8'h68, 8'h60, 8'h98, 8'h80};
    e0   = '{F0V, F0V, F0V,
             REGBUSSEL | REGBUSEN | RAMADDR, REGBUSEN | RAMADDR,
             REGBUSSEL | REGBUSEN | RAMADDR, REGBUSEN | RAMADDR};
    e1   = '{RDSEL | RAMOE | REGWR0 | INCR, RDSEL | RAMOE | REGWR1 | INCR,
             RDSEL | RAMOE | LOADPC,
             REGBUSEN | RAMWE, REGBUSSEL | REGBUSEN | RAMWE,
             RDSEL | RAMOE | REGWR1, RDSEL | RAMOE | REGWR0};
    incs = '{2, 2, 1, 1, 1, 1, 1};
    doReset();
    for (int unsigned k = 0; k < 7; k++) begin
      exp4 = '{F0V, F1V, e0[k], e1[k]};
      bus4 = '{8'h00, irs[k], 8'h2a, 8'h2a};
      incCount = 0;
      for (int unsigned p = 0; p < 4; p++) begin
        i_bus = bus4[p];
        #1;
        checks++;
        if (obs !== exp4[p]) begin
          errors++;
          $display("FAIL instr4 ir=%h phase=%0d got=%h want=%h", irs[k], p, obs, exp4[p]);
        end
        if (obs[1]) incCount++;
        @(negedge i_clk);
      end
      checks++;
      if (incCount !== incs[k]) begin
        errors++;
        $display("FAIL incr_count ir=%h got=%0d want=%0d", irs[k], incCount, incs[k]);
      end
    end
    i_bus = 8'h00; #1;
    checks++;
    if (obs !== F0V) begin
      errors++;
      $display("FAIL instr4_return got=%h want=%h", obs, F0V);
    end
  endtask

  task automatic test_alu();
    logic [7:0]  irs [3];
    logic [18:0] e0 [3];
    logic [18:0] e1 [3];
    logic [18:0] exp5 [5];
    irs = '{8'h53, 8'h4D, 8'h5F};
    e0  = '{REGBUSEN | ALUBWR, REGBUSSEL | REGBUSEN | ALUBWR, REGBUSSEL | REGBUSEN | ALUBWR};
    e1  = '{OP3 | ALUSEL, OP1 | ALUSUB, OP3 | SHL | ALUSEL};
    doReset();
    for (int unsigned k = 0; k < 3; k++) begin
      exp5 = '{F0V, F1V, e0[k], e1[k], e1[k] | ALUOE | (irs[k][4] ? REGWR1 : REGWR0)};
      for (int unsigned p = 0; p < 5; p++) begin
        i_bus = (p == 1) ? irs[k] : 8'h00;
        #1;
        checks++;
        if (obs !== exp5[p]) begin
          errors++;
          $display("FAIL alu ir=%h phase=%0d got=%h want=%h", irs[k], p, obs, exp5[p]);
        end
        @(negedge i_clk);
      end
    end
    i_bus = 8'h00; #1;
    checks++;
    if (obs !== F0V) begin
      errors++;
      $display("FAIL alu_return got=%h want=%h", obs, F0V);
    end
  endtask

  task automatic test_jcc();
    jcase_t      cs [9];
    logic [18:0] expA [5];
    logic [18:0] expJ [4];
    logic        taken;
    cs = '{'{1'b1, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b1},
           '{1'b0, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0},
           '{1'b1, 1'b0, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0},
           '{1'b0, 1'b0, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b1},
           '{1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 1'b1},
           '{1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b0, 1'b0},
           '{1'b1, 1'b0, 8'hC1, 1'b0, 1'b1, 1'b0, 1'b1},
           '{1'b0, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0, 1'b1},
           '{1'b1, 1'b1, 8'hC2, 1'b1, 1'b0, 1'b1, 1'b0}};
    expA = '{F0V, F1V, REGBUSEN | ALUBWR, 19'h0, ALUOE | REGWR0};
    doReset();
    for (int unsigned k = 0; k < 9; k++) begin
      i_aluFlagZ = cs[k].aZ;
      i_aluFlagN = cs[k].aN;
      for (int unsigned p = 0; p < 5; p++) begin
        i_bus = (p == 1) ? 8'h40 : 8'h00;
        #1;
        checks++;
        if (obs !== expA[p]) begin
          errors++;
          $display("FAIL jcc_alu case=%0d phase=%0d got=%h want=%h", k, p, obs, expA[p]);
        end
        @(negedge i_clk);
      end
      i_aluFlagZ = cs[k].jZ;
      i_aluFlagN = cs[k].jN;
      taken = LATCHED ? cs[k].tLatch : cs[k].tLive;
      expJ = '{F0V, F1V, F0V, RDSEL | RAMOE | (taken ? LOADPC : INCR)};
      for (int unsigned p = 0; p < 4; p++) begin
        i_bus = (p == 1) ? cs[k].ir : 8'h17;
        #1;
        checks++;
        if (obs !== expJ[p]) begin
          errors++;
          $display("FAIL jcc case=%0d ir=%h phase=%0d got=%h want=%h", k, cs[k].ir, p, obs, expJ[p]);
        end
        @(negedge i_clk);
      end
    end
    i_aluFlagZ = 1'b0;
    i_aluFlagN = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  busS [10];
    logic [18:0] expS [10];
    busS = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h20, 8'h2a, 8'h2a, 8'h00, 8'h00};
    expS = '{F0V, F1V, F0V, F1V, F0V, F1V, F0V, RDSEL | RAMOE | REGWR0 | INCR, F0V, F1V};
    doReset();
    for (int unsigned c = 0; c < 10; c++) begin
      i_bus = busS[c];
      #1;
      checks++;
      if (obs !== expS[c]) begin
        errors++;
        $display("FAIL back_to_back cycle=%0d got=%h want=%h", c, obs, expS[c]);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_mid_reset();
    doReset();
    i_bus = 8'h00; #1;
    @(negedge i_clk);
    i_bus = 8'h68; #1;
    @(negedge i_clk);
    i_bus = 8'h00; #1;
    checks++;
    if (obs !== (REGBUSSEL | REGBUSEN | RAMADDR)) begin
      errors++;
      $display("FAIL midrst_st_exec0 got=%h want=%h", obs, REGBUSSEL | REGBUSEN | RAMADDR);
    end
    watchWe = 1'b1;
    weSeen  = 1'b0;
    #2;
    i_nReset = 1'b0;
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL midrst_immediate got=%h want=%h", obs, 19'h0);
    end
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge i_clk); #1;
      checks++;
      if (obs !== 19'h0) begin
        errors++;
        $display("FAIL midrst_hold cycle=%0d got=%h want=%h", i, obs, 19'h0);
      end
    end
    @(negedge i_clk);
    i_nReset = 1'b1;
    #1;
    checks++;
    if (obs !== F0V) begin
      errors++;
      $display("FAIL midrst_release got=%h want=%h", obs, F0V);
    end
    @(negedge i_clk); #1;
    watchWe = 1'b0;
    checks++;
    if (weSeen !== 1'b0) begin
      errors++;
      $display("FAIL midrst_no_write got=%b want=%b", weSeen, 1'b0);
    end
    checks++;
    if (obs !== F1V) begin
      errors++;
      $display("FAIL midrst_fetch1 got=%h want=%h", obs, F1V);
    end
  endtask

  task automatic test_hlt();
    doReset();
    i_bus = 8'h00; #1;
    @(negedge i_clk);
    i_bus = 8'hE0; #1;
    @(negedge i_clk);
    for (int unsigned i = 0; i < 20; i++) begin
      i_bus = 8'($urandom);
      i_aluFlagZ = 1'($urandom);
      i_aluFlagN = 1'($urandom);
      #1;
      checks++;
      if (obs !== HALTED) begin
        errors++;
        $display("FAIL halt cycle=%0d got=%h want=%h", i, obs, HALTED);
      end
      @(negedge i_clk);
    end
    i_nReset = 1'b0;
    i_bus = 8'h00;
    #1;
    checks++;
    if (obs !== 19'h0) begin
      errors++;
      $display("FAIL halt_reset got=%h want=%h", obs, 19'h0);
    end
    @(negedge i_clk);
    i_nReset = 1'b1;
    #1;
    checks++;
    if (obs !== F0V) begin
      errors++;
      $display("FAIL halt_exit got=%h want=%h", obs, F0V);
    end
    i_aluFlagZ = 1'b0;
    i_aluFlagN = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_nReset   = 1'b1;
    i_bus      = 8'h00;
    i_aluFlagN = 1'b0;
    i_aluFlagZ = 1'b0;
    #1;
    test_reset();
    test_four_cycle();
    test_alu();
    test_jcc();
    test_back_to_back();
    test_mid_reset();
    test_hlt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: i_clk input 1 (rising-edge clock), i_nReset input 1 (asynchronous active-low reset).
REQ-002 The block SHALL have these data and status ports: i_bus input 8 (shared data bus, sampled for instruction and immediate bytes); i_aluFlagN input 1; i_aluFlagZ input 1; o_halted output 1.
REQ-003 The block SHALL drive the datapath controls: o_ctrlAluOE, o_ctrlAluSub, o_ctrlAluOp[1:0], o_ctrlAluBWr, o_ctrlAluShiftLeft, o_ctrlAluSel, o_ctrlRegWr0, o_ctrlRegWr1, o_ctrlRegBusSel, o_ctrlRegBusEn, o_ctrlRamAddressEn, o_ctrlRamWriteEn, o_ctrlRamReadDataSelect, o_ctrlRamOE, o_ctrlLoadPC, o_ctrlIncrPC, o_ctrlPCOe; all are outputs, 1 bit wide except o_ctrlAluOp.

Function
REQ-004 The instruction byte SHALL be decoded as: IR[7:5] opcode, IR[4] rd, IR[3] rs, IR[2] sub/shiftLeft, IR[1:0] aluOp or cond.
REQ-005 The opcodes SHALL be: 000 NOP, 001 LDI rd,imm, 010 ALU rd,rs, 011 ST [rs]=r(~rs), 100 LD rd=[rs], 101 JMP imm, 110 JCC imm, 111 HLT.
REQ-006 The states SHALL be FETCH0, FETCH1, EXEC0, EXEC1, EXEC2 and HALT; outputs SHALL be a Moore decode of the state and IR.
REQ-007 FETCH0 SHALL assert PCOe and RamAddressEn.
REQ-008 FETCH1 SHALL assert RamReadDataSelect, RamOE and IncrPC, with IR <= i_bus at the closing edge.
REQ-009 After FETCH1 the block SHALL go to HALT for HLT, FETCH0 for NOP, and EXEC0 otherwise.
REQ-010 LDI/JMP/JCC EXEC0 SHALL assert PCOe and RamAddressEn.
REQ-011 LDI/JMP/JCC EXEC1 SHALL assert RamReadDataSelect and RamOE, plus: LDI -> RegWr(rd) and IncrPC; JMP -> LoadPC; JCC taken -> LoadPC; JCC not taken -> IncrPC.
REQ-012 JCC cond SHALL be: 00 Z, 01 !Z, 10 N, 11 !N.
REQ-013 ALU EXEC0 SHALL assert RegBusSel=rs, RegBusEn and AluBWr.
REQ-014 ALU EXEC1 SHALL drive AluSel=rd, AluOp=IR[1:0], AluSub=IR[2] when AluOp!=11, and ShiftLeft=IR[2] when AluOp==11.
REQ-015 ALU EXEC2 SHALL hold the EXEC1 ALU controls and assert AluOE and RegWr(rd).
REQ-016 ST EXEC0 SHALL assert RegBusSel=rs, RegBusEn and RamAddressEn; ST EXEC1 SHALL assert RegBusSel=~rs, RegBusEn and RamWriteEn.
REQ-017 LD EXEC0 SHALL match ST EXEC0; LD EXEC1 SHALL assert RamReadDataSelect, RamOE and RegWr(rd).
REQ-018 The last EXEC state of every instruction SHALL return to FETCH0.
REQ-019 At most one of AluOE, RegBusEn, RamOE and PCOe SHALL be high in any cycle.
REQ-020 RegWr0 and RegWr1 SHALL never be high together.
REQ-021 Instruction cycle counts SHALL be: NOP 2, ALU 5, all others 4.
REQ-022 HALT SHALL drive all ctrl outputs to 0 and o_halted=1, and SHALL be left only by reset.

Reset
REQ-023 While i_nReset=0, all ctrl outputs SHALL be 0, o_halted SHALL be 0, IR SHALL be 0x00 and the state SHALL be FETCH0, all taking effect asynchronously.
REQ-024 Reset asserted mid-instruction SHALL abandon the instruction without issuing any further write strobe.
REQ-025 The first cycle after reset release SHALL be FETCH0.

Configuration
REQ-026 With CTRL_SEQ_FLAG_LATCH_EN defined, a 2-bit {N,Z} register SHALL capture i_aluFlagN/i_aluFlagZ at the closing edge of ALU EXEC2, reset to 00, and JCC SHALL evaluate the latched flags.
REQ-027 Without CTRL_SEQ_FLAG_LATCH_EN, JCC SHALL evaluate the live i_aluFlagN/i_aluFlagZ during its EXEC1, and no flag register SHALL exist.

Structure
REQ-028 Package edic_ctrl_pkg SHALL hold the opcode enum, the state enum, the JCC cond enum and the IR field bit-position constants.
REQ-029 The combinational state+IR -> ctrl decode SHALL be a single sub-module, control_decode; the state register, IR and flag latch SHALL stay in control_sequencer.

Verification
REQ-030 Reset scenario: hold i_nReset=0 for 10 cycles then release -> all outputs 0 during reset; first cycle after release PCOe=1, RamAddressEn=1.
REQ-031 LDI scenario: i_bus supplies 0x20 then 0x2a -> RegWr0=1 in EXEC1, two IncrPC pulses total, FETCH0 on the 5th cycle.
REQ-032 ALU scenario: IR=0x53 (ALU r1,r0,op 11, right shift) -> EXEC0 RegBusSel=0, AluBWr=1; EXEC1 AluOp=11, ShiftLeft=0, AluSel=1; EXEC2 AluOE=1, RegWr1=1.
REQ-033 JCC scenario: IR=0xC0 with Z=1 -> LoadPC=1, IncrPC=0 in EXEC1; with Z=0 -> IncrPC=1, LoadPC=0; repeat with the flag changed after the ALU instruction in both macro builds.
REQ-034 Mid-operation reset scenario: drop i_nReset during ST EXEC0 -> RamWriteEn never asserted, all outputs 0 immediately, FETCH0 after release.
REQ-035 HLT scenario: IR=0xE0 -> o_halted=1 and all ctrl outputs 0 for 20 cycles, then reset returns to FETCH0.
